// File: rtl/vpg_multimode_if.sv
// Video pattern generator bus: run-time mode select, pixel request towards the
// upstream frame buffer with the returned external pixel, and the registered
// HDMI TX video outputs.
interface vpg_multimode_if #(
  parameter int CW  = 8,
  parameter int XYW = 12
);
  logic [1:0]      mode;
  logic [3*CW-1:0] ext_rgb;
  logic            pix_req;
  logic [XYW-1:0]  pix_x;
  logic [XYW-1:0]  pix_y;
  logic            sof;
  logic            vid_de;
  logic            vid_hs;
  logic            vid_vs;
  logic [CW-1:0]   vid_r;
  logic [CW-1:0]   vid_g;
  logic [CW-1:0]   vid_b;

  modport master (
    input  mode, ext_rgb,
    output pix_req, pix_x, pix_y, sof,
    output vid_de, vid_hs, vid_vs, vid_r, vid_g, vid_b
  );

  modport slave (
    output mode, ext_rgb,
    input  pix_req, pix_x, pix_y, sof,
    input  vid_de, vid_hs, vid_vs, vid_r, vid_g, vid_b
  );
endinterface

// File: rtl/vpg_multimode.sv
// Parametrised video pattern generator: raster timing (DE/HS/VS) for any
// resolution, pixel request with X/Y for a frame buffer, and a per-frame
// selectable pixel source (external, colour bars, grid, gradient).
// All video outputs are registered one cycle behind the raster counters.
module vpg_multimode #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CW       = 8,
  parameter int XYW      = 12
) (
  input  logic            clk,
  input  logic            reset_n,
  vpg_multimode_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [XYW-1:0] XY_ONE    = XYW'(1);
  localparam logic [XYW-1:0] H_LAST    = XYW'(H_TOTAL - 1);
  localparam logic [XYW-1:0] V_LAST    = XYW'(V_TOTAL - 1);
  localparam logic [XYW-1:0] H_ACT_END = XYW'(H_ACTIVE);
  localparam logic [XYW-1:0] V_ACT_END = XYW'(V_ACTIVE);
  localparam logic [XYW-1:0] HS_START  = XYW'(H_ACTIVE + H_FP);
  localparam logic [XYW-1:0] HS_END    = XYW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [XYW-1:0] VS_START  = XYW'(V_ACTIVE + V_FP);
  localparam logic [XYW-1:0] VS_END    = XYW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [XYW-1:0] BAR_LAST  = XYW'(BAR_W - 1);
  localparam logic           HS_ACT    = (HS_POL != 0);
  localparam logic           VS_ACT    = (VS_POL != 0);

  // Bar index to {R,G,B}: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [3*CW-1:0] bar_rgb(input logic [2:0] idx);
    bar_rgb = {{CW{~idx[1]}}, {CW{~idx[2]}}, {CW{~idx[0]}}};
  endfunction

  logic [XYW-1:0]  h_cnt_r;
  logic [XYW-1:0]  v_cnt_r;
  logic [XYW-1:0]  bar_cnt_r;
  logic [2:0]      bar_idx_r;
  logic [1:0]      mode_q_r;
  logic            vid_de_r;
  logic            vid_hs_r;
  logic            vid_vs_r;
  logic            sof_r;
  logic [3*CW-1:0] rgb_r;

  logic            active_s;
  logic            frame_start_s;
  logic            hs_win_s;
  logic            vs_win_s;
  logic [1:0]      mode_eff_s;
  logic [CW-1:0]   grad_sum_s;
  logic [3*CW-1:0] rgb_s;

  assign active_s      = (h_cnt_r < H_ACT_END) && (v_cnt_r < V_ACT_END);
  assign frame_start_s = (h_cnt_r == '0) && (v_cnt_r == '0);
  assign hs_win_s      = (h_cnt_r >= HS_START) && (h_cnt_r < HS_END);
  assign vs_win_s      = (v_cnt_r >= VS_START) && (v_cnt_r < VS_END);
  // The first pixel of a frame already uses the mode being latched there.
  assign mode_eff_s    = frame_start_s ? bus.mode : mode_q_r;
  assign grad_sum_s    = h_cnt_r[CW-1:0] + v_cnt_r[CW-1:0];

  // Raster position: h wraps every line, v advances on each h wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_r <= '0;
      v_cnt_r <= '0;
    end else if (h_cnt_r == H_LAST) begin
      h_cnt_r <= '0;
      v_cnt_r <= (v_cnt_r == V_LAST) ? '0 : (v_cnt_r + XY_ONE);
    end else begin
      h_cnt_r <= h_cnt_r + XY_ONE;
      v_cnt_r <= v_cnt_r;
    end
  end

  // Colour-bar tracker: follows h_cnt so the bar index matches the current pixel;
  // the last bar absorbs any remainder pixels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bar_cnt_r <= '0;
      bar_idx_r <= 3'd0;
    end else if (h_cnt_r == H_LAST) begin
      bar_cnt_r <= '0;
      bar_idx_r <= 3'd0;
    end else if ((h_cnt_r < H_ACT_END) && (bar_cnt_r == BAR_LAST) && (bar_idx_r != 3'd7)) begin
      bar_cnt_r <= '0;
      bar_idx_r <= bar_idx_r + 3'd1;
    end else if (h_cnt_r < H_ACT_END) begin
      bar_cnt_r <= bar_cnt_r + XY_ONE;
      bar_idx_r <= bar_idx_r;
    end else begin
      bar_cnt_r <= bar_cnt_r;
      bar_idx_r <= bar_idx_r;
    end
  end

  // Frame mode register: sampled only at the first position of a frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q_r <= 2'd0;
    end else if (frame_start_s) begin
      mode_q_r <= bus.mode;
    end else begin
      mode_q_r <= mode_q_r;
    end
  end

  // Pixel source select; blanking is always black.
  always_comb begin
    rgb_s = '0;
    if (active_s) begin
      case (mode_eff_s)
        2'd0:    rgb_s = bus.ext_rgb;
        2'd1:    rgb_s = bar_rgb(bar_idx_r);
        2'd2: begin
          if ((h_cnt_r[4:0] == 5'd0) || (v_cnt_r[4:0] == 5'd0)) begin
            rgb_s = '1;
          end else begin
            rgb_s = '0;
          end
        end
        2'd3:    rgb_s = {h_cnt_r[CW-1:0], v_cnt_r[CW-1:0], grad_sum_s};
        default: rgb_s = '0;
      endcase
    end else begin
      rgb_s = '0;
    end
  end

  // Video output stage: timing and colour registered one cycle behind the counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vid_de_r <= 1'b0;
      vid_hs_r <= ~HS_ACT;
      vid_vs_r <= ~VS_ACT;
      sof_r    <= 1'b0;
      rgb_r    <= '0;
    end else begin
      vid_de_r <= active_s;
      vid_hs_r <= hs_win_s ? HS_ACT : ~HS_ACT;
      vid_vs_r <= vs_win_s ? VS_ACT : ~VS_ACT;
      sof_r    <= frame_start_s;
      rgb_r    <= rgb_s;
    end
  end

  assign bus.pix_req = active_s;
  assign bus.pix_x   = h_cnt_r;
  assign bus.pix_y   = v_cnt_r;
  assign bus.sof     = sof_r;
  assign bus.vid_de  = vid_de_r;
  assign bus.vid_hs  = vid_hs_r;
  assign bus.vid_vs  = vid_vs_r;
  assign bus.vid_r   = rgb_r[3*CW-1:2*CW];
  assign bus.vid_g   = rgb_r[2*CW-1:CW];
  assign bus.vid_b   = rgb_r[CW-1:0];

endmodule

// File: tb/tb_vpg_multimode.sv
// Bench for vpg_multimode on a small raster (66x20 active, 82x27 total, HS
// active-low, VS active-high). A frame-level model predicts every output each
// cycle; directed checks pin timing counts and specific pixel colours.
module tb_vpg_multimode;
  localparam int HA = 66, HF = 4, HSW = 8, HB = 4;
  localparam int VA = 20, VF = 2, VSW = 2, VB = 3;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int BW = HA / 8;
  localparam int CW = 8, XYW = 12;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  vpg_multimode_if #(.CW(CW), .XYW(XYW)) bus ();

  vpg_multimode #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(0), .VS_POL(1), .CW(CW), .XYW(XYW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // External pixel source: always driven, so blanking must be forced black by the DUT.
  assign bus.ext_rgb = {bus.pix_x[7:0], bus.pix_y[7:0], 8'hA5};

  // ---------------- behavioural model ----------------
  int          mh = 0, mv = 0, mmode = 0;
  logic        e_de = 1'b0, e_hs = 1'b1, e_vs = 1'b0, e_sof = 1'b0;
  logic [23:0] e_rgb = 24'h0;

  function automatic logic [23:0] exp_pixel(input int x, input int y, input int m);
    int bar;
    logic [7:0] s;
    if (x >= HA || y >= VA) return 24'h0;
    case (m)
      0: return {x[7:0], y[7:0], 8'hA5};
      1: begin
        bar = x / BW;
        if (bar > 7) bar = 7;
        case (bar)
          0: return 24'hFFFFFF;
          1: return 24'hFFFF00;
          2: return 24'h00FFFF;
          3: return 24'h00FF00;
          4: return 24'hFF00FF;
          5: return 24'hFF0000;
          6: return 24'h0000FF;
          default: return 24'h000000;
        endcase
      end
      2: return ((x % 32 == 0) || (y % 32 == 0)) ? 24'hFFFFFF : 24'h000000;
      default: begin
        s = 8'(x + y);
        return {x[7:0], y[7:0], s};
      end
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mh <= 0; mv <= 0; mmode <= 0;
      e_de <= 1'b0; e_hs <= 1'b1; e_vs <= 1'b0; e_sof <= 1'b0; e_rgb <= 24'h0;
    end else begin
      e_de  <= (mh < HA) && (mv < VA);
      e_hs  <= !((mh >= HA + HF) && (mh < HA + HF + HSW));
      e_vs  <= (mv >= VA + VF) && (mv < VA + VF + VSW);
      e_sof <= (mh == 0) && (mv == 0);
      e_rgb <= exp_pixel(mh, mv, ((mh == 0) && (mv == 0)) ? int'(bus.mode) : mmode);
      if ((mh == 0) && (mv == 0)) mmode <= int'(bus.mode);
      mh <= (mh == HT - 1) ? 0 : mh + 1;
      mv <= (mh == HT - 1) ? ((mv == VT - 1) ? 0 : mv + 1) : mv;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    checks++;
    if ({bus.vid_de, bus.vid_hs, bus.vid_vs, bus.sof} !== {e_de, e_hs, e_vs, e_sof} ||
        {bus.vid_r, bus.vid_g, bus.vid_b} !== e_rgb ||
        bus.pix_req !== ((mh < HA) && (mv < VA)) ||
        bus.pix_x !== 12'(mh) || bus.pix_y !== 12'(mv)) begin
      errors++;
      $display("FAIL model t=%0t got de%b hs%b vs%b sof%b rgb=%h req%b x=%0d y=%0d required de%b hs%b vs%b sof%b rgb=%h x=%0d y=%0d",
               $time, bus.vid_de, bus.vid_hs, bus.vid_vs, bus.sof,
               {bus.vid_r, bus.vid_g, bus.vid_b}, bus.pix_req, bus.pix_x, bus.pix_y,
               e_de, e_hs, e_vs, e_sof, e_rgb, mh, mv);
    end
  end

  // ---------------- directed checks ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  // Wait until the counters sit at (x,y), then return the pixel one cycle later.
  task automatic grab(input int x, input int y, output logic [23:0] rgb);
    int n;
    n = 0;
    while (!((bus.pix_x == 12'(x)) && (bus.pix_y == 12'(y))) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL grab_timeout x=%0d y=%0d got none required position", x, y);
    end
    @(negedge clk);
    rgb = {bus.vid_r, bus.vid_g, bus.vid_b};
  endtask

  logic [23:0] px;
  int n, de_cnt, hs_lo, rises, rise1, rise2;
  logic prev_de;

  initial begin
    bus.mode = 2'd1;
    reset_n  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_de",  32'(bus.vid_de), 32'h0);
    chk("rst_hs",  32'(bus.vid_hs), 32'h1);
    chk("rst_vs",  32'(bus.vid_vs), 32'h0);
    chk("rst_sof", 32'(bus.sof),    32'h0);
    chk("rst_rgb", 32'({bus.vid_r, bus.vid_g, bus.vid_b}), 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("first_de",  32'(bus.vid_de), 32'h1);
    chk("first_sof", 32'(bus.sof),    32'h1);
    chk("first_rgb", 32'({bus.vid_r, bus.vid_g, bus.vid_b}), 32'hFFFFFF);

    // Frame timing measured from this sof to the next.
    n = 0; de_cnt = 0; hs_lo = 0; rises = 0; rise1 = -1; rise2 = -1; prev_de = 1'b0;
    do begin
      if (bus.vid_de && !prev_de) begin
        if (rises == 0) rise1 = n;
        if (rises == 1) rise2 = n;
        rises++;
      end
      prev_de = bus.vid_de;
      if (bus.vid_de) de_cnt++;
      if (!bus.vid_hs) hs_lo++;
      @(negedge clk);
      n++;
    end while (!bus.sof && n < 5000);
    chk("frame_period", 32'(n), 32'(HT * VT));
    chk("line_period",  32'(rise2 - rise1), 32'(HT));
    chk("de_lines",     32'(rises), 32'(VA));
    chk("de_per_frame", 32'(de_cnt), 32'(HA * VA));
    chk("hs_low_frame", 32'(hs_lo), 32'(HSW * VT));

    // Colour bars, including the remainder pixels that belong to black.
    grab(0, 1, px);  chk("bar_x0",  32'(px), 32'hFFFFFF);
    grab(8, 1, px);  chk("bar_x8",  32'(px), 32'hFFFF00);
    grab(16, 1, px); chk("bar_x16", 32'(px), 32'h00FFFF);
    grab(48, 1, px); chk("bar_x48", 32'(px), 32'h0000FF);
    grab(63, 1, px); chk("bar_x63", 32'(px), 32'h000000);
    grab(65, 1, px); chk("bar_x65", 32'(px), 32'h000000);

    // External passthrough from the next frame; blanking stays black.
    bus.mode = 2'd0;
    grab(0, 0, px);  chk("ext_0_0",  32'(px), 32'h0000A5);
    grab(5, 3, px);  chk("ext_5_3",  32'(px), 32'h0503A5);
    grab(70, 3, px); chk("ext_blank", 32'(px), 32'h0);

    // Mode change mid-frame: bars finish the frame, grid starts with the next sof.
    bus.mode = 2'd1;
    grab(0, 0, px);  chk("bars_again", 32'(px), 32'hFFFFFF);
    grab(0, 5, px);
    bus.mode = 2'd2;
    grab(8, 19, px); chk("bars_to_end", 32'(px), 32'hFFFF00);
    grab(0, 0, px);  chk("grid_0_0", 32'(px), 32'hFFFFFF);
    chk("grid_sof", 32'(bus.sof), 32'h1);
    grab(1, 1, px);  chk("grid_1_1",  32'(px), 32'h000000);
    grab(32, 1, px); chk("grid_32_1", 32'(px), 32'hFFFFFF);

    // Gradient with wrapping sum.
    bus.mode = 2'd3;
    grab(0, 0, px);   chk("grad_0_0",   32'(px), 32'h000000);
    grab(10, 7, px);  chk("grad_10_7",  32'(px), 32'h0A0711);
    grab(60, 19, px); chk("grad_60_19", 32'(px), 32'h3C134F);

    // Asynchronous reset mid-line.
    grab(29, 10, px);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_de",  32'(bus.vid_de), 32'h0);
    chk("arst_hs",  32'(bus.vid_hs), 32'h1);
    chk("arst_vs",  32'(bus.vid_vs), 32'h0);
    chk("arst_sof", 32'(bus.sof),    32'h0);
    chk("arst_rgb", 32'({bus.vid_r, bus.vid_g, bus.vid_b}), 32'h0);
    chk("arst_x",   32'(bus.pix_x), 32'h0);
    chk("arst_y",   32'(bus.pix_y), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rerun_de",  32'(bus.vid_de), 32'h1);
    chk("rerun_sof", 32'(bus.sof),    32'h1);
    grab(2, 1, px);  chk("rerun_grad", 32'(px), 32'h020103);

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
